// File: rtl/lsu_mm_sched.sv
// lsu_mm_sched: sequences one matrix-multiply command by first loading the
// input buffer and then the weight buffer through a shared RAM read port.
// It routes each read return to the buffer that owns it and waits for both
// buffers to report end of stream.
// Optional feature: define LSU_MM_SCHED_PERF_CNT_EN to add sched_perf_cycles.
module lsu_mm_sched (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_vld,
  output logic         cmd_rdy,
  input  logic [3:0]   cmd_row_len,
  input  logic [3:0]   cmd_col_len,
  input  logic [11:0]  cmd_iram_addr,
  input  logic [11:0]  cmd_wram_addr,
  output logic         sched_ibuf_start,
  output logic         sched_wbuf_start,
  output logic         sched_ibuf_vld,
  output logic         sched_wbuf_vld,
  output logic [3:0]   sched_buf_row_len,
  output logic [3:0]   sched_buf_col_len,
  output logic [11:0]  sched_ibuf_addr,
  output logic [11:0]  sched_wbuf_addr,
  input  logic         ibuf_ram_read_vld,
  input  logic         wbuf_ram_read_vld,
  input  logic [7:0]   ibuf_ram_read_addr,
  input  logic [7:0]   wbuf_ram_read_addr,
  output logic         sched_ram_read_vld,
  output logic [7:0]   sched_ram_read_addr,
  input  logic [127:0] ram_sched_read_data,
  output logic         sched_ibuf_alloc_vld,
  output logic         sched_wbuf_alloc_vld,
  output logic [7:0]   sched_alloc_addr,
  output logic [127:0] sched_alloc_data,
  input  logic         ibuf_mxu_end,
  input  logic         wbuf_mxu_end,
  output logic         sched_busy,
  output logic         sched_done
`ifdef LSU_MM_SCHED_PERF_CNT_EN
  ,
  output logic [15:0]  sched_perf_cycles
`endif
);

  typedef enum logic [2:0] {
    IDLE, START_I, LOAD_I, START_W, LOAD_W, RUN, DONE
  } state_t;

  state_t      state, next_state;
  logic [4:0]  rd_cnt;
  logic        last_read;
  logic        end_i, end_w;
  logic        ret_i, ret_w;
  logic [7:0]  ret_addr;
  logic [3:0]  row_len, col_len;
  logic [11:0] iram_addr, wram_addr;

  assign sched_buf_row_len    = row_len;
  assign sched_buf_col_len    = col_len;
  assign sched_ibuf_addr      = iram_addr;
  assign sched_wbuf_addr      = wram_addr;
  assign sched_ibuf_alloc_vld = ret_i;
  assign sched_wbuf_alloc_vld = ret_w;
  assign sched_alloc_addr     = ret_addr;
  assign sched_alloc_data     = (ret_i | ret_w) ? ram_sched_read_data : 128'd0;

  // The 5-bit compare lets col_len=15 run the full 16 reads without wrapping.
  assign last_read = (rd_cnt == {1'b0, col_len});

  // Next-state, read-port arbitration and status decode.
  always_comb begin
    next_state          = state;
    cmd_rdy             = 1'b0;
    sched_ibuf_start    = 1'b0;
    sched_wbuf_start    = 1'b0;
    sched_ibuf_vld      = 1'b0;
    sched_wbuf_vld      = 1'b0;
    sched_ram_read_vld  = 1'b0;
    sched_ram_read_addr = 8'd0;
    sched_busy          = 1'b1;
    sched_done          = 1'b0;
    case (state)
      IDLE: begin
        cmd_rdy    = 1'b1;
        sched_busy = 1'b0;
        if (cmd_vld) next_state = START_I;
      end
      START_I: begin
        sched_ibuf_start = 1'b1;
        sched_ibuf_vld   = 1'b1;
        next_state       = LOAD_I;
      end
      LOAD_I: begin
        sched_ibuf_vld      = 1'b1;
        sched_ram_read_vld  = ibuf_ram_read_vld;
        sched_ram_read_addr = ibuf_ram_read_vld ? ibuf_ram_read_addr : 8'd0;
        if (ibuf_ram_read_vld && last_read) next_state = START_W;
      end
      START_W: begin
        sched_ibuf_vld   = 1'b1;
        sched_wbuf_start = 1'b1;
        sched_wbuf_vld   = 1'b1;
        next_state       = LOAD_W;
      end
      LOAD_W: begin
        sched_ibuf_vld      = 1'b1;
        sched_wbuf_vld      = 1'b1;
        sched_ram_read_vld  = wbuf_ram_read_vld;
        sched_ram_read_addr = wbuf_ram_read_vld ? wbuf_ram_read_addr : 8'd0;
        if (wbuf_ram_read_vld && last_read) next_state = RUN;
      end
      RUN: begin
        sched_ibuf_vld = 1'b1;
        sched_wbuf_vld = 1'b1;
        if ((end_i | ibuf_mxu_end) && (end_w | wbuf_mxu_end)) next_state = DONE;
      end
      DONE: begin
        sched_done = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State, command latch, read counter, end flags and read-return tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_cnt    <= 5'd0;
      end_i     <= 1'b0;
      end_w     <= 1'b0;
      ret_i     <= 1'b0;
      ret_w     <= 1'b0;
      ret_addr  <= 8'd0;
      row_len   <= 4'd0;
      col_len   <= 4'd0;
      iram_addr <= 12'd0;
      wram_addr <= 12'd0;
    end else begin
      state <= next_state;
      ret_i <= sched_ram_read_vld && (state == LOAD_I);
      ret_w <= sched_ram_read_vld && (state == LOAD_W);
      if (sched_ram_read_vld) begin
        ret_addr <= sched_ram_read_addr;
        rd_cnt   <= last_read ? 5'd0 : rd_cnt + 5'd1;
      end
      if (state == IDLE && cmd_vld) begin
        row_len   <= cmd_row_len;
        col_len   <= cmd_col_len;
        iram_addr <= cmd_iram_addr;
        wram_addr <= cmd_wram_addr;
        rd_cnt    <= 5'd0;
        end_i     <= 1'b0;
        end_w     <= 1'b0;
      end
      if (state == RUN) begin
        end_i <= end_i | ibuf_mxu_end;
        end_w <= end_w | wbuf_mxu_end;
      end
    end
  end

`ifdef LSU_MM_SCHED_PERF_CNT_EN
  // Busy-cycle counter: restarts on accept, saturates, holds while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sched_perf_cycles <= 16'd0;
    end else if (state == IDLE) begin
      if (cmd_vld) sched_perf_cycles <= 16'd0;
    end else if (sched_perf_cycles != 16'hFFFF) begin
      sched_perf_cycles <= sched_perf_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_mm_sched.sv
// Directed self-checking bench for lsu_mm_sched (optionally with
// LSU_MM_SCHED_PERF_CNT_EN defined to check sched_perf_cycles).
module tb_lsu_mm_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_vld, cmd_rdy;
  logic [3:0]   cmd_row_len, cmd_col_len;
  logic [11:0]  cmd_iram_addr, cmd_wram_addr;
  logic         sched_ibuf_start, sched_wbuf_start, sched_ibuf_vld, sched_wbuf_vld;
  logic [3:0]   sched_buf_row_len, sched_buf_col_len;
  logic [11:0]  sched_ibuf_addr, sched_wbuf_addr;
  logic         ibuf_ram_read_vld, wbuf_ram_read_vld;
  logic [7:0]   ibuf_ram_read_addr, wbuf_ram_read_addr;
  logic         sched_ram_read_vld;
  logic [7:0]   sched_ram_read_addr;
  logic [127:0] ram_data;
  logic         sched_ibuf_alloc_vld, sched_wbuf_alloc_vld;
  logic [7:0]   sched_alloc_addr;
  logic [127:0] sched_alloc_data;
  logic         ibuf_mxu_end, wbuf_mxu_end;
  logic         sched_busy, sched_done;
`ifdef LSU_MM_SCHED_PERF_CNT_EN
  logic [15:0]  sched_perf_cycles;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lsu_mm_sched dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_row_len(cmd_row_len), .cmd_col_len(cmd_col_len),
    .cmd_iram_addr(cmd_iram_addr), .cmd_wram_addr(cmd_wram_addr),
    .sched_ibuf_start(sched_ibuf_start), .sched_wbuf_start(sched_wbuf_start),
    .sched_ibuf_vld(sched_ibuf_vld), .sched_wbuf_vld(sched_wbuf_vld),
    .sched_buf_row_len(sched_buf_row_len), .sched_buf_col_len(sched_buf_col_len),
    .sched_ibuf_addr(sched_ibuf_addr), .sched_wbuf_addr(sched_wbuf_addr),
    .ibuf_ram_read_vld(ibuf_ram_read_vld), .wbuf_ram_read_vld(wbuf_ram_read_vld),
    .ibuf_ram_read_addr(ibuf_ram_read_addr), .wbuf_ram_read_addr(wbuf_ram_read_addr),
    .sched_ram_read_vld(sched_ram_read_vld), .sched_ram_read_addr(sched_ram_read_addr),
    .ram_sched_read_data(ram_data),
    .sched_ibuf_alloc_vld(sched_ibuf_alloc_vld), .sched_wbuf_alloc_vld(sched_wbuf_alloc_vld),
    .sched_alloc_addr(sched_alloc_addr), .sched_alloc_data(sched_alloc_data),
    .ibuf_mxu_end(ibuf_mxu_end), .wbuf_mxu_end(wbuf_mxu_end),
    .sched_busy(sched_busy), .sched_done(sched_done)
`ifdef LSU_MM_SCHED_PERF_CNT_EN
    , .sched_perf_cycles(sched_perf_cycles)
`endif
  );

  // RAM model: one-cycle latency, data tagged with the row address.
  always @(posedge clk) ram_data <= {8{8'hA5, sched_ram_read_addr}};

  function automatic logic [127:0] pat(input logic [7:0] a);
    return {8{8'hA5, a}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic checkIdle(input string tag);
    chk1({tag, ".cmd_rdy"}, cmd_rdy, 1'b1);
    chk1({tag, ".busy"}, sched_busy, 1'b0);
    chk1({tag, ".done"}, sched_done, 1'b0);
    chk1({tag, ".istart"}, sched_ibuf_start, 1'b0);
    chk1({tag, ".wstart"}, sched_wbuf_start, 1'b0);
    chk1({tag, ".ivld"}, sched_ibuf_vld, 1'b0);
    chk1({tag, ".wvld"}, sched_wbuf_vld, 1'b0);
    chk1({tag, ".rdvld"}, sched_ram_read_vld, 1'b0);
    chk1({tag, ".ialloc"}, sched_ibuf_alloc_vld, 1'b0);
    chk1({tag, ".walloc"}, sched_wbuf_alloc_vld, 1'b0);
    chk({tag, ".adata"}, sched_alloc_data, 128'd0);
  endtask

  task automatic issue(input logic [3:0] row, input logic [3:0] col,
                       input logic [11:0] ia, input logic [11:0] wa);
    cmd_vld = 1'b1; cmd_row_len = row; cmd_col_len = col;
    cmd_iram_addr = ia; cmd_wram_addr = wa;
    settle();
    chk1("accept.cmd_rdy", cmd_rdy, 1'b1);
    tick();
    cmd_vld = 1'b0;
  endtask

  // Both buffers request every cycle; the non-owner presents address 0xEE.
  task automatic startPhase(input bit is_w, input logic [7:0] prev_base, input int prev_n);
    ibuf_ram_read_vld = 1'b1; wbuf_ram_read_vld = 1'b1;
    ibuf_ram_read_addr = 8'hEE; wbuf_ram_read_addr = 8'hEE;
    settle();
    chk1("start.rdvld", sched_ram_read_vld, 1'b0);
    chk1("start.istart", sched_ibuf_start, !is_w);
    chk1("start.wstart", sched_wbuf_start, is_w);
    chk1("start.ivld", sched_ibuf_vld, 1'b1);
    chk1("start.wvld", sched_wbuf_vld, is_w);
    chk1("start.walloc", sched_wbuf_alloc_vld, 1'b0);
    if (is_w) begin
      chk1("startW.ialloc_last", sched_ibuf_alloc_vld, 1'b1);
      chk("startW.aaddr", 128'(sched_alloc_addr), 128'(prev_base + 8'(prev_n - 1)));
      chk("startW.adata", sched_alloc_data, pat(prev_base + 8'(prev_n - 1)));
    end else begin
      chk1("startI.ialloc", sched_ibuf_alloc_vld, 1'b0);
    end
    tick();
  endtask

  task automatic loadPhase(input bit is_w, input logic [7:0] base, input int n);
    logic [7:0] a;
    for (int k = 0; k < n; k++) begin
      a = base + 8'(k);
      ibuf_ram_read_vld = 1'b1; wbuf_ram_read_vld = 1'b1;
      ibuf_ram_read_addr = is_w ? 8'hEE : a;
      wbuf_ram_read_addr = is_w ? a : 8'hEE;
      settle();
      chk1("load.rdvld", sched_ram_read_vld, 1'b1);
      chk("load.rdaddr", 128'(sched_ram_read_addr), 128'(a));
      chk1("load.wvld", sched_wbuf_vld, is_w);
      chk1("load.istart", sched_ibuf_start, 1'b0);
      if (k > 0) begin
        chk1("load.ialloc", sched_ibuf_alloc_vld, !is_w);
        chk1("load.walloc", sched_wbuf_alloc_vld, is_w);
        chk("load.aaddr", 128'(sched_alloc_addr), 128'(a - 8'd1));
        chk("load.adata", sched_alloc_data, pat(a - 8'd1));
      end else begin
        chk1("load0.ialloc", sched_ibuf_alloc_vld, 1'b0);
        chk1("load0.walloc", sched_wbuf_alloc_vld, 1'b0);
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_vld = 1'b0; cmd_row_len = 4'd0; cmd_col_len = 4'd0;
    cmd_iram_addr = 12'd0; cmd_wram_addr = 12'd0;
    ibuf_ram_read_vld = 1'b0; wbuf_ram_read_vld = 1'b0;
    ibuf_ram_read_addr = 8'd0; wbuf_ram_read_addr = 8'd0;
    ibuf_mxu_end = 1'b0; wbuf_mxu_end = 1'b0;
    tick(); tick();
    settle();
    checkIdle("reset");
    chk("reset.row", 128'(sched_buf_row_len), 128'd0);
    chk("reset.iaddr", 128'(sched_ibuf_addr), 128'd0);
    rst_n = 1'b1;
    tick();

    // Basic flow with both ends in the same cycle and a command held in RUN.
    issue(4'd3, 4'd3, 12'h040, 12'h100);
    settle();
    chk("basic.row", 128'(sched_buf_row_len), 128'd3);
    chk("basic.col", 128'(sched_buf_col_len), 128'd3);
    chk("basic.iaddr", 128'(sched_ibuf_addr), 128'h040);
    chk("basic.waddr", 128'(sched_wbuf_addr), 128'h100);
    chk1("basic.busy", sched_busy, 1'b1);
    startPhase(1'b0, 8'h00, 0);
    loadPhase(1'b0, 8'h04, 4);
    startPhase(1'b1, 8'h04, 4);
    loadPhase(1'b1, 8'h10, 4);
    cmd_vld = 1'b1; cmd_row_len = 4'd9; cmd_col_len = 4'd9;
    cmd_iram_addr = 12'hABC; cmd_wram_addr = 12'hDEF;
    settle();
    chk1("run.rdvld", sched_ram_read_vld, 1'b0);
    chk1("run.walloc_last", sched_wbuf_alloc_vld, 1'b1);
    chk("run.aaddr", 128'(sched_alloc_addr), 128'h13);
    chk1("run.ivld", sched_ibuf_vld, 1'b1);
    chk1("run.wvld", sched_wbuf_vld, 1'b1);
    chk1("run.cmd_rdy", cmd_rdy, 1'b0);
    tick();
    ibuf_ram_read_vld = 1'b0; wbuf_ram_read_vld = 1'b0;
    settle();
    chk("run.row_held", 128'(sched_buf_row_len), 128'd3);
    chk("run.iaddr_held", 128'(sched_ibuf_addr), 128'h040);
    chk1("run.done0", sched_done, 1'b0);
    tick();
    cmd_vld = 1'b0; ibuf_mxu_end = 1'b1; wbuf_mxu_end = 1'b1;
    settle();
    chk1("sameEnd.done0", sched_done, 1'b0);
    tick();
    ibuf_mxu_end = 1'b0; wbuf_mxu_end = 1'b0;
    settle();
    chk1("sameEnd.done", sched_done, 1'b1);
    chk1("sameEnd.busy", sched_busy, 1'b1);
    chk1("sameEnd.ivld", sched_ibuf_vld, 1'b0);
    chk1("sameEnd.wvld", sched_wbuf_vld, 1'b0);
    chk1("sameEnd.cmd_rdy0", cmd_rdy, 1'b0);
    tick();
    settle();
    checkIdle("basicEnd");
`ifdef LSU_MM_SCHED_PERF_CNT_EN
    chk("basic.perf", 128'(sched_perf_cycles), 128'd14);
`endif
    tick();

    // Maximum-size command, ends arriving five cycles apart.
    issue(4'd15, 4'd15, 12'h800, 12'hC00);
    startPhase(1'b0, 8'h00, 0);
    loadPhase(1'b0, 8'h80, 16);
    startPhase(1'b1, 8'h80, 16);
    loadPhase(1'b1, 8'hC0, 16);
    settle();
    chk1("max.no17th", sched_ram_read_vld, 1'b0);
    chk("max.aaddr", 128'(sched_alloc_addr), 128'hCF);
    tick();
    ibuf_ram_read_vld = 1'b0; wbuf_ram_read_vld = 1'b0;
    wbuf_mxu_end = 1'b1;
    settle();
    chk1("diffEnd.N", sched_done, 1'b0);
    tick();
    wbuf_mxu_end = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk1("diffEnd.wait_done", sched_done, 1'b0);
      chk1("diffEnd.wait_wvld", sched_wbuf_vld, 1'b1);
      tick();
    end
    ibuf_mxu_end = 1'b1;
    settle();
    chk1("diffEnd.N5", sched_done, 1'b0);
    tick();
    ibuf_mxu_end = 1'b0;
    settle();
    chk1("diffEnd.done", sched_done, 1'b1);
    tick();
    settle();
    checkIdle("maxEnd");
`ifdef LSU_MM_SCHED_PERF_CNT_EN
    chk("max.perf", 128'(sched_perf_cycles), 128'd42);
`endif
    tick();

    // Reset in the middle of LOAD_W aborts without a done pulse.
    issue(4'd3, 4'd3, 12'h040, 12'h100);
    startPhase(1'b0, 8'h00, 0);
    loadPhase(1'b0, 8'h04, 4);
    startPhase(1'b1, 8'h04, 4);
    loadPhase(1'b1, 8'h10, 2);
    rst_n = 1'b0;
    tick();
    ibuf_ram_read_vld = 1'b0; wbuf_ram_read_vld = 1'b0;
    settle();
    checkIdle("midRst");
    chk("midRst.row", 128'(sched_buf_row_len), 128'd0);
    chk("midRst.col", 128'(sched_buf_col_len), 128'd0);
    chk("midRst.iaddr", 128'(sched_ibuf_addr), 128'd0);
    chk("midRst.waddr", 128'(sched_wbuf_addr), 128'd0);
    chk("midRst.aaddr", 128'(sched_alloc_addr), 128'd0);
`ifdef LSU_MM_SCHED_PERF_CNT_EN
    chk("midRst.perf", 128'(sched_perf_cycles), 128'd0);
`endif
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      settle();
      chk1("postRst.done", sched_done, 1'b0);
      chk1("postRst.cmd_rdy", cmd_rdy, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_mm_sched.md
LSU_MM_SCHED -- requirements
Module: lsu_mm_sched

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset:
  clk  in  1  clock, all state on rising edge
  rst_n  in  1  synchronous active-low reset
REQ-002 The block SHALL have these command ports:
  cmd_vld  in  1  command valid
  cmd_rdy  out  1  command accept (high only in IDLE)
  cmd_row_len  in  4  matrix row length minus 1
  cmd_col_len  in  4  matrix column length minus 1
  cmd_iram_addr  in  12  input-matrix byte start address
  cmd_wram_addr  in  12  weight-matrix byte start address
REQ-003 The block SHALL have these buffer control ports:
  sched_ibuf_start / sched_wbuf_start  out  1  one-cycle start pulse to input / weight buffer
  sched_ibuf_vld / sched_wbuf_vld  out  1  buffer control valid
  sched_buf_row_len / sched_buf_col_len  out  4  latched lengths, shared by both buffers
  sched_ibuf_addr / sched_wbuf_addr  out  12  latched start addresses
REQ-004 The block SHALL have these RAM port and buffer return ports:
  ibuf_ram_read_vld / wbuf_ram_read_vld  in  1  buffer read request
  ibuf_ram_read_addr / wbuf_ram_read_addr  in  8  buffer read row address
  sched_ram_read_vld  out  1  shared RAM read enable
  sched_ram_read_addr  out  8  shared RAM row address
  ram_sched_read_data  in  128  RAM data, 1-cycle latency
  sched_ibuf_alloc_vld / sched_wbuf_alloc_vld  out  1  return strobe to owning buffer
  sched_alloc_addr  out  8  returned row address
  sched_alloc_data  out  128  returned row data
  ibuf_mxu_end / wbuf_mxu_end  in  1  buffer stream-finished
  sched_busy  out  1  high whenever state is not IDLE
  sched_done  out  1  one-cycle completion pulse

Function
REQ-005 The FSM SHALL have the states IDLE, START_I, LOAD_I, START_W, LOAD_W, RUN, DONE.
REQ-006 In IDLE, the handshake cmd_vld&cmd_rdy SHALL latch all cmd_* fields, clear the read counter, and move to START_I.
REQ-007 The START_I state SHALL assert sched_ibuf_start and sched_ibuf_vld for exactly 1 cycle, then move to LOAD_I.
REQ-008 In LOAD_I, ibuf_ram_read_vld SHALL pass combinationally to sched_ram_read_vld/addr, and each forwarded read SHALL increment a 5-bit read counter.
REQ-009 When the counter reaches col_len+1, the FSM SHALL move to START_W and clear the counter; wbuf requests in LOAD_I SHALL be ignored.
REQ-010 START_W and LOAD_W SHALL mirror START_I and LOAD_I for the weight buffer, then move to RUN.
REQ-011 sched_ibuf_vld SHALL be held high from START_I through RUN, and sched_wbuf_vld from START_W through RUN; both SHALL be low in IDLE and DONE.
REQ-012 Read return: one cycle after each forwarded read, the block SHALL assert the owner's alloc_vld, with sched_alloc_addr equal to the registered read address and sched_alloc_data equal to ram_sched_read_data.
REQ-013 The return for the final read of LOAD_I SHALL still go to ibuf, even though the FSM is already in START_W.
REQ-014 In RUN, the block SHALL set sticky flags on ibuf_mxu_end and wbuf_mxu_end; once both flags are set (same cycle allowed), the FSM SHALL move to DONE.
REQ-015 DONE SHALL assert sched_done for 1 cycle, then return to IDLE; a new command SHALL be acceptable on the cycle after DONE.
REQ-016 If both buffers request in the same cycle, only the buffer owning the current LOAD state SHALL be granted; sched_ram_read_vld SHALL be 0 outside LOAD_I and LOAD_W.
REQ-017 Counter arithmetic SHALL be 5-bit so col_len=15 gives 16 reads without wrap; the maximum load is 16 reads per buffer.

Reset
REQ-018 With rst_n low at a clock edge, the state SHALL become IDLE, and all counters, flags and latched fields SHALL become 0.
REQ-019 After reset, cmd_rdy SHALL be 1 and every other output SHALL be 0, including a pending alloc return; reset mid-operation SHALL abort with no sched_done.

Configuration
REQ-020 With macro LSU_MM_SCHED_PERF_CNT_EN defined, the block SHALL add output sched_perf_cycles [15:0]. The counter SHALL clear on command accept, count every non-IDLE cycle, saturate at 16'hFFFF, and hold its value in IDLE. Without the macro, the port and counter SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-021 The bench SHALL cover the basic flow: cmd row=3, col=3, iram=0x040, wram=0x100, with buffers requesting every cycle. Required: exactly 4 reads at 0x04-0x07 during LOAD_I, then 4 at 0x10-0x13 during LOAD_W; each alloc is 1 cycle later and goes to the correct buffer.
REQ-022 The bench SHALL cover a maximum-size command with col=15: exactly 16 grants per buffer with no counter wrap; the return of the 16th ibuf read is delivered to ibuf during START_W.
REQ-023 The bench SHALL cover ends in the same cycle: ibuf_mxu_end and wbuf_mxu_end both pulse in one cycle in RUN; sched_done pulses on the next cycle, then cmd_rdy=1.
REQ-024 The bench SHALL cover ends in different cycles: wbuf_mxu_end at cycle N, ibuf_mxu_end at N+5; DONE is entered only after N+5.
REQ-025 The bench SHALL cover conflict and busy cases: wbuf requests during LOAD_I are not granted; cmd_vld held during RUN sees cmd_rdy=0 and no new latch.
REQ-026 The bench SHALL cover reset and the perf counter: rst_n low during LOAD_W gives IDLE with all outputs 0 and no sched_done. With LSU_MM_SCHED_PERF_CNT_EN, sched_perf_cycles equals the non-IDLE cycle count of the REQ-021 run.
